// File: rtl/sequenciador_acoes_pkg.sv
// Shared definitions for the action sequencer: action and motor encodings,
// duration constants, the HOLD select code and small decode helpers.
package sequenciador_acoes_pkg;

  typedef enum logic [2:0] {
    PARADO   = 3'd0,
    FRENTE   = 3'd1,
    ESQUERDA = 3'd2,
    DIREITA  = 3'd3,
    RE       = 3'd4,
    DESVIO   = 3'd5
  } acao_t;

  typedef enum logic [1:0] {
    MOTOR_PARADO = 2'b00,
    MOTOR_FRENTE = 2'b01,
    MOTOR_RE     = 2'b10
  } motor_t;

  localparam logic [3:0] DUR_CURTA  = 4'd2;
  localparam logic [3:0] DUR_MEDIA  = 4'd4;
  localparam logic [3:0] DUR_LONGA  = 4'd8;
  localparam logic [3:0] DESVIO_LEN = 4'd2;
  localparam logic [1:0] SEL_HOLD   = 2'b11;

  // Duration for a switch setting. HOLD has no duration of its own; an action
  // entered under HOLD latches the shortest one so the latch is always valid
  // once the switches are released.
  function automatic logic [3:0] duracao(input logic [1:0] sel);
    case (sel)
      2'b00:   duracao = DUR_CURTA;
      2'b01:   duracao = DUR_MEDIA;
      2'b10:   duracao = DUR_LONGA;
      default: duracao = DUR_CURTA;
    endcase
  endfunction

  // Cyclic action list, RE wraps back to FRENTE.
  function automatic acao_t proxima(input acao_t a);
    case (a)
      FRENTE:   proxima = ESQUERDA;
      ESQUERDA: proxima = DIREITA;
      DIREITA:  proxima = RE;
      default:  proxima = FRENTE;
    endcase
  endfunction

  function automatic motor_t motor_esq_de(input acao_t a);
    case (a)
      FRENTE, DIREITA: motor_esq_de = MOTOR_FRENTE;
      RE, DESVIO:      motor_esq_de = MOTOR_RE;
      default:         motor_esq_de = MOTOR_PARADO;
    endcase
  endfunction

  function automatic motor_t motor_dir_de(input acao_t a);
    case (a)
      FRENTE, ESQUERDA: motor_dir_de = MOTOR_FRENTE;
      RE, DESVIO:       motor_dir_de = MOTOR_RE;
      default:          motor_dir_de = MOTOR_PARADO;
    endcase
  endfunction

endpackage

// File: rtl/sequenciador_acoes_if.sv
// Control/status bundle of the action sequencer.
//   tick, habilita, chave_0, chave_1, obstaculo : towards the sequencer
//   acao, motor_esq, motor_dir, contagem, fim_acao : from the sequencer
// slave  : used by the sequencer itself
// master : used by whoever drives the inputs and observes the outputs
interface sequenciador_acoes_if;
  import sequenciador_acoes_pkg::*;

  logic       tick;
  logic       habilita;
  logic       chave_0;
  logic       chave_1;
  logic       obstaculo;
  acao_t      acao;
  motor_t     motor_esq;
  motor_t     motor_dir;
  logic [2:0] contagem;
  logic       fim_acao;

  modport slave (
    input  tick, habilita, chave_0, chave_1, obstaculo,
    output acao, motor_esq, motor_dir, contagem, fim_acao
  );

  modport master (
    output tick, habilita, chave_0, chave_1, obstaculo,
    input  acao, motor_esq, motor_dir, contagem, fim_acao
  );
endinterface

// File: rtl/contador_acao.sv
// Tick counter for the current action with its duration latch.
//   clk, reset : clock and synchronous active-high reset
//   limpar     : clear the count, keep the latched duration
//   carregar   : clear the count and latch a new duration n (wins over limpar)
//   tick       : advance the count (wraps to 0 on the last tick)
//   n          : duration to latch, in ticks (2, 4 or 8)
//   contagem   : ticks elapsed in the current action
//   expirou    : count sits on the last tick of the latched duration
module contador_acao
  import sequenciador_acoes_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  input  logic       limpar,
  input  logic       carregar,
  input  logic       tick,
  input  logic [3:0] n,
  output logic [2:0] contagem,
  output logic       expirou
);

  logic [3:0] n_lat;

  // Terminal-count compare; the owner qualifies it with tick to get expiry.
  assign expirou = ({1'b0, contagem} == (n_lat - 4'd1));

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of block evaluation order.
  always_ff @(posedge clk) begin
    if (reset) begin
      contagem <= 3'd0;
      // NOTE: the duration latch is real state read right after reset, so it
      // gets a defined reset value like the counter.
      n_lat    <= DUR_CURTA;
    end else if (carregar) begin
      contagem <= 3'd0;
      n_lat    <= n;
    end else if (limpar) begin
      contagem <= 3'd0;
    end else if (tick) begin
      contagem <= expirou ? 3'd0 : contagem + 3'd1;
    end
  end

endmodule

// File: rtl/sequenciador_acoes.sv
// Action sequencer for the autonomous toy. Steps through FRENTE, ESQUERDA,
// DIREITA, RE with switch-selected durations, preempted by an evasive DESVIO
// manoeuvre on obstacles and forced to PARADO when not enabled.
//   clk, reset : clock and synchronous active-high reset
//   bus        : sequenciador_acoes_if.slave (inputs tick, habilita, chave_0,
//                chave_1, obstaculo; registered outputs acao, motor_esq,
//                motor_dir, contagem, fim_acao)
module sequenciador_acoes
  import sequenciador_acoes_pkg::*;
(
  input  logic                  clk,
  input  logic                  reset,
  sequenciador_acoes_if.slave   bus
);

  logic [1:0] sel;
  logic       hold;
  logic       em_lista;
  logic       expirou;
  logic       expira;
  acao_t      nxt;
  logic       fim_nxt;
  logic       limpar;
  logic       carregar;
  logic       tick_cnt;
  logic [3:0] n_carga;

  assign sel      = {bus.chave_1, bus.chave_0};
  assign hold     = (sel == SEL_HOLD);
  assign em_lista = bus.acao inside {FRENTE, ESQUERDA, DIREITA, RE};
  assign expira   = bus.tick & expirou;

  contador_acao u_contador (
    .clk      (clk),
    .reset    (reset),
    .limpar   (limpar),
    .carregar (carregar),
    .tick     (tick_cnt),
    .n        (n_carga),
    .contagem (bus.contagem),
    .expirou  (expirou)
  );

  // Transition decision in priority order: habilita low, obstacle, HOLD,
  // then tick expiry / tick count. Any action entry reloads the counter.
  always_comb begin
    // NOTE: every output of this block gets a default first, so no path can
    // leave one unassigned and infer a latch.
    nxt      = bus.acao;
    fim_nxt  = 1'b0;
    limpar   = 1'b0;
    carregar = 1'b0;
    tick_cnt = 1'b0;
    n_carga  = duracao(sel);

    if (!bus.habilita) begin
      nxt    = PARADO;
      limpar = 1'b1;
    end else if (bus.acao == PARADO) begin
      if (!hold) begin
        nxt      = FRENTE;
        carregar = 1'b1;
      end
    end else if (em_lista && bus.obstaculo) begin
      nxt      = DESVIO;
      carregar = 1'b1;
      n_carga  = DESVIO_LEN;
    end else if (bus.acao == DESVIO) begin
      // The manoeuvre ignores HOLD and the obstacle sensor.
      tick_cnt = bus.tick;
      if (expira) begin
        nxt      = DIREITA;
        carregar = 1'b1;
        fim_nxt  = 1'b1;
      end
    end else if (!hold) begin
      tick_cnt = bus.tick;
      if (expira) begin
        nxt      = proxima(bus.acao);
        carregar = 1'b1;
        fim_nxt  = 1'b1;
      end
    end
  end

  // State register with the motor decode registered alongside, so all
  // outputs change on the same edge.
  always_ff @(posedge clk) begin
    if (reset) begin
      bus.acao      <= PARADO;
      bus.motor_esq <= MOTOR_PARADO;
      bus.motor_dir <= MOTOR_PARADO;
      bus.fim_acao  <= 1'b0;
    end else begin
      bus.acao      <= nxt;
      bus.motor_esq <= motor_esq_de(nxt);
      bus.motor_dir <= motor_dir_de(nxt);
      bus.fim_acao  <= fim_nxt;
    end
  end

endmodule

// File: tb/tb_sequenciador_acoes.sv
// Self-checking bench for sequenciador_acoes: a directed 32-tick run with
// 8-tick durations, then randomized phases compared cycle by cycle against a
// behavioural model of the action rules.
module tb_sequenciador_acoes;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  sequenciador_acoes_if bus ();

  sequenciador_acoes dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string tag, input int got, input int exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
    end
  endtask

  // Reference model: action index 0..5 (PARADO, FRENTE, ESQUERDA, DIREITA,
  // RE, DESVIO), ticks elapsed, latched duration and the end-of-action flag.
  int m_act, m_cnt, m_n, m_fim;
  int esq_tab [6] = '{0, 1, 0, 1, 2, 2};
  int dir_tab [6] = '{0, 1, 1, 0, 2, 2};

  function automatic int dur(input int s);
    return (s == 3) ? 2 : (2 << s);
  endfunction

  task automatic model_step(input bit r, input bit h, input int s, input bit o, input bit t);
    m_fim = 0;
    if (r) begin
      m_act = 0; m_cnt = 0; m_n = 2;
    end else if (!h) begin
      m_act = 0; m_cnt = 0;
    end else if (m_act == 0) begin
      if (s != 3) begin m_act = 1; m_cnt = 0; m_n = dur(s); end
    end else if (m_act >= 1 && m_act <= 4 && o) begin
      m_act = 5; m_cnt = 0; m_n = 2;
    end else if (m_act == 5) begin
      if (t) begin
        if (m_cnt == 1) begin m_act = 3; m_cnt = 0; m_n = dur(s); m_fim = 1; end
        else m_cnt++;
      end
    end else if (s != 3 && t) begin
      if (m_cnt == m_n - 1) begin
        m_act = (m_act % 4) + 1; m_cnt = 0; m_n = dur(s); m_fim = 1;
      end else m_cnt++;
    end
  endtask

  task automatic compare_all();
    check("acao",      int'(bus.acao),      m_act);
    check("motor_esq", int'(bus.motor_esq), esq_tab[m_act]);
    check("motor_dir", int'(bus.motor_dir), dir_tab[m_act]);
    check("contagem",  int'(bus.contagem),  m_cnt);
    check("fim_acao",  int'(bus.fim_acao),  m_fim);
  endtask

  // Called at a negedge: apply inputs, let one edge pass, compare at the next
  // negedge.
  task automatic run_cycle(input bit r, input bit h, input int s, input bit o, input bit t);
    logic [1:0] sv;
    sv            = s[1:0];
    reset         = r;
    bus.habilita  = h;
    bus.chave_1   = sv[1];
    bus.chave_0   = sv[0];
    bus.obstaculo = o;
    bus.tick      = t;
    @(posedge clk);
    model_step(r, h, s, o, t);
    @(negedge clk);
    compare_all();
  endtask

  typedef struct {
    int cycles;
    int tick_pct;
    int obs_pct;
    int hab_off_pct;
    int sel_chg_pct;
    int hold_ok;
    int rst_pct;
  } fase_t;

  fase_t fases [4] = '{
    '{300, 30,  0, 0, 0, 0, 0},
    '{600, 40,  0, 0, 2, 0, 0},
    '{800, 45,  8, 1, 3, 1, 0},
    '{800, 50, 15, 3, 5, 1, 1}
  };

  initial begin
    int fims, maxc, sel;
    bit last_t, t, o, h, r;

    reset = 1'b1;
    bus.habilita = 1'b0; bus.chave_0 = 1'b0; bus.chave_1 = 1'b0;
    bus.obstaculo = 1'b0; bus.tick = 1'b0;
    m_act = 0; m_cnt = 0; m_n = 2; m_fim = 0;
    @(negedge clk);

    run_cycle(1, 0, 0, 0, 0);
    run_cycle(1, 1, 0, 1, 1);
    check("reset_acao", int'(bus.acao), 0);
    check("reset_motors", int'({bus.motor_esq, bus.motor_dir}), 0);
    check("reset_contagem", int'(bus.contagem), 0);
    check("reset_fim", int'(bus.fim_acao), 0);

    // 8-tick durations: 32 ticks walk the full list back to FRENTE.
    run_cycle(0, 1, 2, 0, 0);
    check("start_frente", int'(bus.acao), 1);
    fims = 0; maxc = 0;
    for (int i = 0; i < 32; i++) begin
      run_cycle(0, 1, 2, 0, 1);
      fims += int'(bus.fim_acao);
      if (int'(bus.contagem) > maxc) maxc = int'(bus.contagem);
      run_cycle(0, 1, 2, 0, 0);
      fims += int'(bus.fim_acao);
    end
    check("loop32_acao", int'(bus.acao), 1);
    check("loop32_fims", fims, 4);
    check("loop32_maxc", maxc, 7);
    check("loop32_contagem", int'(bus.contagem), 0);

    // Randomized phases against the model.
    last_t = 1'b0; o = 1'b0; h = 1'b1;
    for (int p = 0; p < 4; p++) begin
      sel = 0;
      for (int c = 0; c < fases[p].cycles; c++) begin
        if ($urandom_range(0, 99) < fases[p].sel_chg_pct)
          sel = fases[p].hold_ok ? $urandom_range(0, 3) : $urandom_range(0, 2);
        if ($urandom_range(0, 99) < fases[p].obs_pct) o = !o;
        if (fases[p].obs_pct == 0) o = 1'b0;
        h = ($urandom_range(0, 99) >= fases[p].hab_off_pct);
        r = ($urandom_range(0, 99) < fases[p].rst_pct);
        t = !last_t && ($urandom_range(0, 99) < fases[p].tick_pct);
        last_t = t;
        run_cycle(r, h, sel, o, t);
      end
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/sequenciador_acoes.md
# sequenciador_acoes

Action sequencer for the autonomous toy. It steps the toy through its cyclic action list: FRENTE, ESQUERDA, DIREITA, RE, then back to FRENTE. Each action lasts 2, 4 or 8 ticks, selected by the two duration switches. An obstacle input preempts the sequence with a fixed evasive manoeuvre. The block sits between the tick prescaler and the motor drivers, and replaces the free-running count/OR-reset scheme with a single registered controller.

## Interface
- No parameters; durations and encodings are fixed constants in the shared package.
- clk  in  1  system clock
- reset  in  1  reset; synchronous, active-high, wins over every other input
- tick  in  1  one-clk pulse from the prescaler; the time base for durations
- habilita  in  1  run enable; low forces PARADO
- chave_0  in  1  duration select, LSB
- chave_1  in  1  duration select, MSB
- obstaculo  in  1  obstacle sensor, level, already synchronised
- acao  out  3  current action: PARADO=0, FRENTE=1, ESQUERDA=2, DIREITA=3, RE=4, DESVIO=5
- motor_esq  out  2  left motor: 00 stop, 01 forward, 10 reverse
- motor_dir  out  2  right motor, same encoding
- contagem  out  3  ticks elapsed in the current action (0..7)
- fim_acao  out  1  one-clk pulse when an action ends by duration expiry

## Operation
- Reset values: acao=PARADO, motors 00/00, contagem=0, fim_acao=0, duration latch=2.
- Duration select {chave_1,chave_0}:
  - 00 → 2 ticks
  - 01 → 4 ticks
  - 10 → 8 ticks
  - 11 → HOLD: state and contagem frozen, motors keep their current values, ticks ignored.
- The duration is latched on entry to every action. Switch changes mid-action affect only the next action.
- Motor map:
  - PARADO 00/00
  - FRENTE 01/01
  - ESQUERDA 00/01
  - DIREITA 01/00
  - RE 10/10
  - DESVIO 10/10
- PARADO → FRENTE: on the first clk with habilita=1. contagem=0 and the duration is latched.
- Running action, tick=1, contagem=N-1:
  - advance to the next action in the list, wrapping RE→FRENTE
  - contagem←0
  - fim_acao=1 for that cycle
- Running action, tick=1, contagem<N-1: contagem+1.
- obstaculo=1 in FRENTE, ESQUERDA, DIREITA or RE → DESVIO.
  - contagem←0, no fim_acao.
  - DESVIO always lasts 2 ticks, regardless of switches and HOLD, then goes to DIREITA with a freshly latched duration.
  - obstaculo is ignored while in DESVIO.
  - If obstaculo is still high in DIREITA, DESVIO is re-entered on the next clk.
- habilita=0 in any state → PARADO next clk, contagem=0, no fim_acao.
- Priority, highest first: reset, habilita=0, obstaculo, HOLD, tick expiry, tick count.
- Obstacle and expiry on the same clk: obstaculo wins and fim_acao stays 0.

## Timing
- All outputs are registered. Changes are visible on the clk edge that samples the triggering input; there is no extra pipeline stage.
- Action length is exactly N tick pulses, independent of tick spacing, provided ticks are at least 1 clk apart.
- fim_acao is asserted for the same single clk in which acao shows the new action.
- Reset mid-action returns all outputs to their reset values on the next edge. The sequence always restarts at FRENTE.
- contagem never exceeds N-1. With 8 ticks it wraps 7→0 on expiry.

## Structure
- Shared package:
  - action codes (3 bits)
  - motor codes (2 bits)
  - duration constants 2/4/8
  - HOLD select code 2'b11
  - DESVIO length 2
- Sub-module contador_acao holds the tick counter, duration latch and terminal-count compare.
  - Inputs: clk, reset, limpar, carregar, tick, n.
  - Outputs: contagem, expirou.
  - It replaces contar_2/contar_4/contar_8 and the OR reset.
- The top level holds the state register, transition logic and motor decode.

## Test plan
- Switches 00, habilita=1, tick every 4 clk → FRENTE held 2 ticks. Then acao=2, motors 00/01, fim_acao single pulse, contagem 0,1,0.
- Switches 10 → each action lasts 8 ticks, contagem reaches 7. acao returns to FRENTE after 32 ticks with 4 fim_acao pulses.
- In FRENTE with switches 00, change to 10 after tick 1 → FRENTE ends at tick 2, then ESQUERDA lasts 8 ticks.
- In ESQUERDA, obstaculo rises on the same clk as the expiring tick → acao=5, motors 10/10, fim_acao=0. After 2 ticks acao=3 with obstaculo low. With obstaculo held high, DESVIO is re-entered 1 clk after reaching DIREITA.
- Switches 11 at contagem=1 → 5 ticks cause no change. Restoring 00 makes the next tick end the action.
- reset during RE at contagem=5 → all outputs 0 next clk. habilita=0 in FRENTE → PARADO; raising habilita restarts FRENTE at contagem=0.
